// File: rtl/load_store_unit.sv
// Load/store unit: one word-aligned single-beat memory access per handshake,
// with store lane replication, load extension, alignment/funct3 checks and a response timeout.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_ALIGN   = 2'd1;
    localparam logic [1:0] ERR_FUNCT3  = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_ERR, S_DONE} state_t;

    state_t           r_state;
    logic             r_is_store;
    logic [2:0]       r_funct3;
    logic [1:0]       r_off;
    logic [1:0]       r_err;
    logic [CNT_W-1:0] r_cnt;
    logic             r_req_ready;
    logic             r_rsp_valid;
    logic [31:0]      r_rsp_rdata;
    logic [1:0]       r_rsp_err;
    logic             r_mem_req;
    logic             r_mem_we;
    logic [31:0]      r_mem_addr;
    logic [3:0]       r_mem_wmask;
    logic [31:0]      r_mem_wdata;

    logic             w_illegal;
    logic             w_misalign;
    logic [1:0]       w_err_code;
    logic [3:0]       w_wmask;
    logic [31:0]      w_wdata;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [31:0]      w_ext;

    // Request decode: legality, alignment and store lane placement from live inputs
    always_comb begin
        w_illegal  = req_is_store ? (req_funct3 > 3'd2)
                                  : (req_funct3 == 3'd3 || req_funct3 > 3'd5);
        w_misalign = 1'b0;
        w_wmask    = 4'b1111;
        w_wdata    = req_wdata;
        case (req_funct3[1:0])
            2'd0: begin
                w_wmask = 4'b0001 << req_addr[1:0];
                w_wdata = {4{req_wdata[7:0]}};
            end
            2'd1: begin
                w_misalign = req_addr[0];
                w_wmask    = req_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata    = {2{req_wdata[15:0]}};
            end
            default: w_misalign = (req_addr[1:0] != 2'b00);
        endcase
        w_err_code = w_illegal ? ERR_FUNCT3 : (w_misalign ? ERR_ALIGN : ERR_OK);
    end

    // Load lane extraction and extension using the latched access
    always_comb begin
        w_byte = 8'(mem_rdata >> {r_off, 3'b000});
        w_half = 16'(mem_rdata >> {r_off[1], 4'b0000});
        case (r_funct3)
            3'd0:    w_ext = {{24{w_byte[7]}}, w_byte};
            3'd1:    w_ext = {{16{w_half[15]}}, w_half};
            3'd2:    w_ext = mem_rdata;
            3'd4:    w_ext = {24'd0, w_byte};
            3'd5:    w_ext = {16'd0, w_half};
            default: w_ext = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_is_store  <= 1'b0;
            r_funct3    <= 3'd0;
            r_off       <= 2'd0;
            r_err       <= ERR_OK;
            r_cnt       <= '0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= ERR_OK;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wmask <= 4'd0;
            r_mem_wdata <= 32'd0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid && r_req_ready) begin
                        r_req_ready <= 1'b0;
                        r_is_store  <= req_is_store;
                        r_funct3    <= req_funct3;
                        r_off       <= req_addr[1:0];
                        r_err       <= w_err_code;
                        r_cnt       <= '0;
                        if (w_err_code != ERR_OK) begin
                            r_state <= S_ERR;
                        end else begin
                            r_state     <= S_REQ;
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= req_is_store;
                            r_mem_addr  <= {req_addr[31:2], 2'b00};
                            r_mem_wmask <= req_is_store ? w_wmask : 4'd0;
                            r_mem_wdata <= req_is_store ? w_wdata : 32'd0;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_gnt) begin
                        r_mem_req   <= 1'b0;
                        r_mem_we    <= 1'b0;
                        r_mem_wmask <= 4'd0;
                        if (r_is_store) begin
                            r_state     <= S_DONE;
                            r_rsp_valid <= 1'b1;
                            r_rsp_rdata <= 32'd0;
                            r_rsp_err   <= ERR_OK;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                // rvalid takes precedence over a coincident timeout
                S_WAIT: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (mem_rvalid) begin
                        r_state     <= S_DONE;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= w_ext;
                        r_rsp_err   <= ERR_OK;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state     <= S_DONE;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= 32'd0;
                        r_rsp_err   <= ERR_TIMEOUT;
                    end
                end
                S_ERR: begin
                    r_state     <= S_DONE;
                    r_rsp_valid <= 1'b1;
                    r_rsp_rdata <= 32'd0;
                    r_rsp_err   <= r_err;
                end
                S_DONE: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wmask = r_mem_wmask;
    assign mem_wdata = r_mem_wdata;
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-side consumer of the ALU's effective address for LOAD and STORE opcodes.
- Accepts one access per handshake and runs a single-beat word-aligned memory transaction (req/gnt, then rvalid for loads).
- Generates byte masks and replicated store data.
- Returns sign- or zero-extended load data to the register writeback path; flags misaligned or illegal accesses without touching memory.

Parameters:
- TIMEOUT_CYCLES, 255, maximum cycles allowed in WAIT_RESP before a bus fault; 8-bit counter, must be 1..255.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  core requests an access this cycle
- req_ready  output  1  unit can accept; high only in IDLE
- req_is_store  input  1  1 = store (opcode 0100011), 0 = load (opcode 0000011)
- req_funct3  input  3  access size/sign, per RV32I encoding
- req_addr  input  32  effective address from ALU (rs1 + imm)
- req_wdata  input  32  rs2 value for stores
- rsp_valid  output  1  one-cycle pulse: access finished
- rsp_rdata  output  32  extended load data; 0 for stores and errors
- rsp_err  output  2  0 ok, 1 misaligned, 2 illegal funct3, 3 bus timeout; valid with rsp_valid
- mem_req  output  1  memory request, held until mem_gnt
- mem_we  output  1  write enable
- mem_addr  output  32  word address, {req_addr[31:2],2'b00}
- mem_wmask  output  4  byte enables; bit i covers wdata[8i+7:8i]
- mem_wdata  output  32  lane-replicated store data
- mem_gnt  input  1  memory accepted request this cycle
- mem_rvalid  input  1  read data valid
- mem_rdata  input  32  read word

Behaviour:
- Reset, asynchronous on rst_n low:
  - State = IDLE; req_ready = 1.
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - mem_req = 0, mem_we = 0, mem_addr = 0, mem_wmask = 0, mem_wdata = 0; timeout counter = 0.
  - Reset mid-transaction abandons the transaction; a later stray mem_rvalid in IDLE is ignored.
- Acceptance: request captured on req_valid && req_ready. Address, funct3, is_store and wdata are latched; later input changes are ignored.
- Legal funct3 values:
  - Load: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU.
  - Store: 0 SB, 1 SH, 2 SW.
  - Anything else is illegal.
- Alignment: halfword needs addr[0] = 0; word needs addr[1:0] = 0.
- States:
  - IDLE: on accept, go to ERR if illegal or misaligned (illegal takes priority), else to REQ.
  - REQ: mem_req = 1 with stable mem_addr, mem_we, mem_wmask and mem_wdata. On mem_gnt, a store goes to DONE and a load goes to WAIT_RESP. No timeout in REQ.
  - WAIT_RESP:
    - Counter increments each cycle.
    - On mem_rvalid: latch the extended data and go to DONE. If mem_rvalid and the counter reaching TIMEOUT_CYCLES coincide, rvalid wins.
    - If the counter reaches TIMEOUT_CYCLES without rvalid: go to DONE with err = 3.
  - ERR: go to DONE with err code and no memory activity.
  - DONE: rsp_valid = 1 for exactly one cycle, then IDLE. req_ready stays 0 until back in IDLE (no back-to-back accept in DONE).
- Latency:
  - Store with immediate gnt: accept cycle N, gnt in N+1, rsp_valid in N+2.
  - Load with immediate gnt and rvalid one cycle later: rsp_valid in N+3.
- mem_rvalid in the same cycle as mem_gnt is not legal for this bus; it is ignored.
- Store lanes, with off = addr[1:0]:
  - SB: wmask = 4'b0001 << off; wdata = {4{b}}.
  - SH: wmask = off[1] ? 4'b1100 : 4'b0011; wdata = {2{h}}.
  - SW: wmask = 4'b1111; wdata = rs2.
- Load extraction:
  - Byte = rdata[8*off +: 8]; halfword = rdata[16*off[1] +: 16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
- Outside REQ, mem_req = 0. mem_wmask = 0 when not a store in REQ.

Test Plan:
- SB addr 0x1003, wdata 0x000000A5, immediate gnt -> mem_addr 0x1000, wmask 4'b1000, wdata 0xA5A5A5A5, rsp_valid 2 cycles after accept, err 0.
- LB addr 0x2001, mem_rdata 0x0000_8000 -> rsp_rdata 0xFFFFFF80; same with LBU -> 0x00000080; LHU addr 0x2002, rdata 0xBEEF1234 -> 0x0000BEEF.
- LW addr 0x3002 -> no mem_req ever asserted, rsp_valid 2 cycles after accept, err 1. Load funct3=3 at addr 0x3000 -> err 2.
- Load with mem_gnt held low 5 cycles -> mem_req and mem_addr stable all 5 cycles, req_ready 0, completes normally after gnt.
- TIMEOUT_CYCLES=4, load granted, no rvalid -> rsp_valid with err 3, rsp_rdata 0. Repeat with rvalid on the timeout cycle -> err 0, data returned.
- Assert rst_n low in WAIT_RESP, then drive mem_rvalid after release -> no rsp_valid, req_ready 1, all outputs at reset values.
